// File: rtl/sdram_rd_stream.sv
// rtl/sdram_rd_stream.sv - sequential-read front end: command in, SDRAM reads out, returned words streamed to host
//
// Ports:
//   clk, rst_n          system clock (rising edge), asynchronous active-low reset
//   cmd_addr/len/valid  command: start word address and word count (0 is a legal no-op)
//   cmd_ready, busy     cmd_ready only in IDLE; busy whenever not in IDLE
//   araddr/arvalid      single-word read requests to the controller, held until arready
//   arready             controller accepts the request this cycle
//   rdata/rvalid        returned words, one-cycle strobe, no backpressure
//   out_data/valid/ready/last  first-word-fall-through stream of returned words
//   err                 sticky: a word returned while no read was outstanding
module sdram_rd_stream #(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [23:0]       cmd_len,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    output logic              busy,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [15:0]       rdata,
    input  logic              rvalid,
    output logic [15:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C  = CW'(FIFO_DEPTH);
    localparam logic [CW:0]   DEPTH_C = {1'b0, FULL_C};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [23:0]       rem;
    logic [23:0]       last_cnt;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     count;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              err_q;
    logic [15:0]       mem [FIFO_DEPTH];

    logic [CW:0] credit_used;
    logic        issue_ok;
    logic        ar_hs;
    logic        cmd_hs;
    logic        push;
    logic        pop;

    // Every word in flight or buffered holds a FIFO slot, so a request is only
    // raised when a slot is guaranteed for its return. Both terms are registered
    // and neither can grow without a handshake, which keeps arvalid stable.
    assign credit_used = {1'b0, outstanding} + {1'b0, count};
    assign issue_ok    = (state == S_ISSUE) && (rem != 24'd0) && (credit_used < DEPTH_C);
    assign ar_hs       = issue_ok && arready;
    assign cmd_hs      = (state == S_IDLE) && cmd_valid;

    // A return with nothing outstanding is a protocol error; drop it.
    assign push = rvalid && (outstanding != '0);
    assign pop  = (count != '0) && out_ready;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign araddr    = addr_q;
    assign arvalid   = issue_ok;
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign out_last  = out_valid && (last_cnt == 24'd1);
    assign err       = err_q;

    // Command sequencing and address generation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            addr_q <= '0;
            rem    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        addr_q <= cmd_addr;
                        rem    <= cmd_len;
                        if (cmd_len != 24'd0) begin
                            state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (ar_hs) begin
                        addr_q <= addr_q + 1'b1;
                        rem    <= rem - 24'd1;
                        if (rem == 24'd1) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // Uses registered values, so IDLE is reached the cycle
                    // after the final word leaves the stream.
                    if ((outstanding == '0) && (count == '0) && (last_cnt == 24'd0)) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Words still to be delivered on the stream; drives out_last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_cnt <= '0;
        end else if (cmd_hs) begin
            last_cnt <= cmd_len;
        end else if (pop && (last_cnt != 24'd0)) begin
            last_cnt <= last_cnt - 24'd1;
        end
    end

    // Reads accepted by the controller whose data has not yet returned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else begin
            case ({ar_hs, push})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Return FIFO bookkeeping; depth is a power of two so pointers wrap freely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (rvalid && (outstanding == '0)) begin
            err_q <= 1'b1;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (count == FULL_C)));

endmodule

// File: tb/tb_sdram_rd_stream.sv
// tb/tb_sdram_rd_stream.sv - directed self-checking bench for sdram_rd_stream
module tb_sdram_rd_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] cmd_addr;
    logic [23:0] cmd_len;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        busy;
    logic [23:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [15:0] rdata;
    logic        rvalid;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        err;

    sdram_rd_stream #(.FIFO_DEPTH(8), .ADDR_W(24)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .busy      (busy),
        .araddr    (araddr),
        .arvalid   (arvalid),
        .arready   (arready),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic        ar_en        = 1'b0;
    logic        inject_stray = 1'b0;
    logic        v_pipe [3];
    logic [15:0] a_pipe [3];
    logic [23:0] iss_q [$];
    logic [16:0] rx_q  [$];
    int          arv_cnt      = 0;
    int          ov_cnt       = 0;
    int          last_pop_cyc = -1;
    int          fall_cyc     = -1;
    logic        prev_busy    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Controller model (returns rdata = araddr[15:0] three cycles after accept)
    // and stream monitor; all sampling and driving happens on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            rvalid  = 1'b0;
            rdata   = 16'h0;
            arready = 1'b0;
            for (int i = 0; i < 3; i++) begin
                v_pipe[i] = 1'b0;
                a_pipe[i] = 16'h0;
            end
            prev_busy = 1'b0;
        end else begin
            rvalid    = v_pipe[2] | inject_stray;
            rdata     = inject_stray ? 16'hdead : a_pipe[2];
            v_pipe[2] = v_pipe[1];
            a_pipe[2] = a_pipe[1];
            v_pipe[1] = v_pipe[0];
            a_pipe[1] = a_pipe[0];
            arready   = ar_en;
            v_pipe[0] = arvalid && arready;
            a_pipe[0] = araddr[15:0];
            if (arvalid && arready) iss_q.push_back(araddr);
            if (arvalid) arv_cnt++;
            if (out_valid) ov_cnt++;
            if (out_valid && out_ready) begin
                rx_q.push_back({out_last, out_data});
                if (out_last) last_pop_cyc = cyc;
            end
            if (prev_busy && !busy) fall_cyc = cyc;
            prev_busy = busy;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] iss_at(input int i);
        if (i < iss_q.size()) return {8'h0, iss_q[i]};
        return 32'hxxxxxxxx;
    endfunction

    function automatic logic [31:0] rx_at(input int i);
        if (i < rx_q.size()) return {15'h0, rx_q[i]};
        return 32'hxxxxxxxx;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [23:0] a, input logic [23:0] l);
        cmd_addr  = a;
        cmd_len   = l;
        cmd_valid = 1'b1;
        tick(1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 300) begin
            tick(1);
            k++;
        end
        chk({tag, "_idle_timeout"}, busy, 0);
        tick(1);
    endtask

    task automatic wait_iss(input string tag, input int n);
        int k = 0;
        while (iss_q.size() < n && k < 100) begin
            tick(1);
            k++;
        end
        chk({tag, "_issue_timeout"}, iss_q.size() >= n, 1);
    endtask

    task automatic chk_reset(input string p);
        chk({p, "cmd_ready"}, cmd_ready, 1);
        chk({p, "busy"},      busy,      0);
        chk({p, "arvalid"},   arvalid,   0);
        chk({p, "araddr"},    araddr,    0);
        chk({p, "out_valid"}, out_valid, 0);
        chk({p, "out_last"},  out_last,  0);
        chk({p, "err"},       err,       0);
    endtask

    task automatic chk_run(input string p, input logic [23:0] base, input int n);
        logic [23:0] e;
        chk({p, "_n_iss"}, iss_q.size(), n);
        chk({p, "_n_rx"},  rx_q.size(),  n);
        for (int i = 0; i < n; i++) begin
            e = base + 24'(i);
            chk({p, "_araddr"}, iss_at(i), {8'h0, e});
            chk({p, "_word"},   rx_at(i),  {15'h0, (i == n - 1), e[15:0]});
        end
    endtask

    task automatic clear_q();
        iss_q.delete();
        rx_q.delete();
    endtask

    initial begin
        int a0;
        int o0;
        logic stable;

        rst_n     = 1'b0;
        cmd_addr  = 24'h0;
        cmd_len   = 24'h0;
        cmd_valid = 1'b0;
        out_ready = 1'b0;
        tick(2);
        chk_reset("rst_");
        rst_n = 1'b1;
        tick(1);

        // Basic four-word read
        clear_q();
        ar_en     = 1'b1;
        out_ready = 1'b1;
        send_cmd(24'h000100, 24'd4);
        chk("t1_first_arvalid", arvalid, 1);
        chk("t1_first_araddr",  araddr,  32'h100);
        wait_idle("t1");
        chk_run("t1", 24'h000100, 4);
        chk("t1_busy_fall_delay", fall_cyc - last_pop_cyc, 2);

        // Consumer backpressure: credit limits issue to FIFO depth
        clear_q();
        out_ready = 1'b0;
        send_cmd(24'h002000, 24'd20);
        tick(30);
        chk("t2_iss_while_blocked", iss_q.size(), 8);
        chk("t2_arvalid_blocked",   arvalid,      0);
        chk("t2_out_valid",         out_valid,    1);
        out_ready = 1'b1;
        wait_idle("t2");
        chk_run("t2", 24'h002000, 20);

        // Address wrap
        clear_q();
        send_cmd(24'hFFFFFE, 24'd4);
        wait_idle("t3");
        chk_run("t3", 24'hFFFFFE, 4);

        // arvalid/araddr held while arready is low
        clear_q();
        send_cmd(24'h000300, 24'd6);
        wait_iss("t4", 2);
        ar_en  = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (!(arvalid === 1'b1 && araddr === 24'h000302)) stable = 1'b0;
        end
        chk("t4_hold_stable", stable, 1);
        chk("t4_iss_during_hold", iss_q.size(), 2);
        ar_en = 1'b1;
        wait_idle("t4");
        chk_run("t4", 24'h000300, 6);

        // Zero-length command and stray return
        clear_q();
        a0 = arv_cnt;
        o0 = ov_cnt;
        send_cmd(24'h000500, 24'd0);
        chk("t5_cmd_ready", cmd_ready, 1);
        tick(5);
        chk("t5_arvalid_cycles",   arv_cnt - a0, 0);
        chk("t5_out_valid_cycles", ov_cnt - o0,  0);
        chk("t5_busy",             busy,         0);
        chk("t5_err_before",       err,          0);
        inject_stray = 1'b1;
        tick(1);
        inject_stray = 1'b0;
        tick(1);
        chk("t5_err_set",       err,       1);
        chk("t5_stray_dropped", out_valid, 0);
        tick(10);
        chk("t5_err_sticky", err, 1);

        // Reset in the middle of a command
        clear_q();
        out_ready = 1'b0;
        send_cmd(24'h000600, 24'd6);
        wait_iss("t6", 3);
        rst_n = 1'b0;
        #1;
        chk_reset("t6_rst_");
        tick(2);
        rst_n = 1'b1;
        clear_q();
        tick(3);
        chk("t6_no_word_after_release", rx_q.size(), 0);
        out_ready = 1'b1;
        send_cmd(24'h000700, 24'd3);
        wait_idle("t6");
        chk_run("t6", 24'h000700, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
